// File: rtl/laser_search_ctrl.sv
// Search scheduler for the LASER two-circle coverage problem: buffers the points,
// sweeps candidate centre pairs through an external evaluator and keeps the best pair.
module laser_search_ctrl #(
  parameter int unsigned NPTS   = 40,
  parameter int unsigned PASSES = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [5:0] RD_ADDR,
  output logic [3:0] RD_X,
  output logic [3:0] RD_Y,
  output logic       EV_REQ,
  output logic [3:0] EV_C1X,
  output logic [3:0] EV_C1Y,
  output logic [3:0] EV_C2X,
  output logic [3:0] EV_C2Y,
  input  logic       EV_ACK,
  input  logic [5:0] EV_CNT,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic [5:0] BEST_CNT,
  output logic       DONE
);

  localparam logic [5:0] LAST_ADDR = 6'(NPTS - 1);
  localparam logic [5:0] RD_LIM    = 6'(NPTS);
  localparam logic [2:0] PASS_LIM  = 3'(PASSES);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, UPDATE, FINISH} state_t;

  state_t     state_q;
  logic [3:0] px_q [NPTS];
  logic [3:0] py_q [NPTS];
  logic [5:0] ld_q;
  logic [7:0] idx_q;
  logic [2:0] pass_q;
  logic       improved_q;
  logic       first_q;
  logic [5:0] cnt_q;
  logic [3:0] b1x_q, b1y_q, b2x_q, b2y_q;
  logic [5:0] bcnt_q;
  logic       ev_req_q;
  logic       done_q;
  logic [3:0] ev_c1x_q, ev_c1y_q, ev_c2x_q, ev_c2y_q;

  logic       wr_en;
  logic [5:0] wr_addr;
  logic       better;
  logic       imp_d;
  logic       last_idx;
  logic       stop;
  logic [7:0] idx_d;
  logic [2:0] pass_d;
  logic [3:0] b1x_d, b1y_d, b2x_d, b2y_d;
  logic [5:0] bcnt_d;
  logic [3:0] nc1x_d, nc1y_d, nc2x_d, nc2y_d;

  // Point buffer is not reset so results survive until the next load overwrites it.
  assign wr_en   = IN_VALID && !RST && (state_q == IDLE || state_q == LOAD);
  assign wr_addr = (state_q == IDLE) ? '0 : ld_q;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      px_q[wr_addr] <= X;
      py_q[wr_addr] <= Y;
    end
  end

  always_comb begin
    RD_X = '0;
    RD_Y = '0;
    if (RD_ADDR < RD_LIM) begin
      RD_X = px_q[RD_ADDR];
      RD_Y = py_q[RD_ADDR];
    end
  end

  // UPDATE-cycle results, plus the candidate presented on the following WAIT entry.
  always_comb begin
    better   = cnt_q > bcnt_q;
    b1x_d    = better ? ev_c1x_q : b1x_q;
    b1y_d    = better ? ev_c1y_q : b1y_q;
    b2x_d    = better ? ev_c2x_q : b2x_q;
    b2y_d    = better ? ev_c2y_q : b2y_q;
    bcnt_d   = better ? cnt_q : bcnt_q;
    imp_d    = improved_q | better;
    last_idx = (idx_q == 8'hFF);
    idx_d    = idx_q + 8'd1;
    pass_d   = last_idx ? pass_q + 3'd1 : pass_q;
    stop     = last_idx && ((pass_d == PASS_LIM) || (pass_d >= 3'd2 && !imp_d));
    if (!pass_d[0]) begin
      nc1x_d = idx_d[7:4];
      nc1y_d = idx_d[3:0];
      nc2x_d = b2x_d;
      nc2y_d = b2y_d;
    end else begin
      nc1x_d = b1x_d;
      nc1y_d = b1y_d;
      nc2x_d = idx_d[7:4];
      nc2y_d = idx_d[3:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ld_q       <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      improved_q <= 1'b0;
      first_q    <= 1'b0;
      cnt_q      <= '0;
      b1x_q      <= 4'd7;
      b1y_q      <= 4'd7;
      b2x_q      <= 4'd7;
      b2y_q      <= 4'd7;
      bcnt_q     <= '0;
      ev_req_q   <= 1'b0;
      done_q     <= 1'b0;
      ev_c1x_q   <= '0;
      ev_c1y_q   <= '0;
      ev_c2x_q   <= '0;
      ev_c2y_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            b1x_q      <= 4'd7;
            b1y_q      <= 4'd7;
            b2x_q      <= 4'd7;
            b2y_q      <= 4'd7;
            bcnt_q     <= '0;
            pass_q     <= '0;
            idx_q      <= '0;
            improved_q <= 1'b0;
            ld_q       <= 6'd1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (IN_VALID) begin
            ld_q <= ld_q + 6'd1;
            if (ld_q == LAST_ADDR) begin
              state_q  <= WAIT;
              ev_req_q <= 1'b1;
              first_q  <= 1'b1;
              ev_c1x_q <= '0;
              ev_c1y_q <= '0;
              ev_c2x_q <= b2x_q;
              ev_c2y_q <= b2y_q;
            end
          end
        end
        WAIT: begin
          // An ack coinciding with the rising request is the engine not having seen it yet.
          if (first_q) begin
            first_q <= 1'b0;
          end else if (EV_ACK) begin
            cnt_q    <= EV_CNT;
            ev_req_q <= 1'b0;
            state_q  <= UPDATE;
          end
        end
        UPDATE: begin
          b1x_q  <= b1x_d;
          b1y_q  <= b1y_d;
          b2x_q  <= b2x_d;
          b2y_q  <= b2y_d;
          bcnt_q <= bcnt_d;
          idx_q  <= idx_d;
          pass_q <= pass_d;
          if (stop) begin
            improved_q <= imp_d;
            done_q     <= 1'b1;
            state_q    <= FINISH;
          end else begin
            improved_q <= last_idx ? 1'b0 : imp_d;
            ev_req_q   <= 1'b1;
            first_q    <= 1'b1;
            ev_c1x_q   <= nc1x_d;
            ev_c1y_q   <= nc1y_d;
            ev_c2x_q   <= nc2x_d;
            ev_c2y_q   <= nc2y_d;
            state_q    <= WAIT;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign EV_REQ   = ev_req_q;
  assign EV_C1X   = ev_c1x_q;
  assign EV_C1Y   = ev_c1y_q;
  assign EV_C2X   = ev_c2x_q;
  assign EV_C2Y   = ev_c2y_q;
  assign C1X      = b1x_q;
  assign C1Y      = b1y_q;
  assign C2X      = b2x_q;
  assign C2Y      = b2y_q;
  assign BEST_CNT = bcnt_q;
  assign DONE     = done_q;

endmodule
